// File: rtl/bp_fe_pc_next_pkg.sv
// Shared front-end types for the next-PC generator: FSM states, address type,
// RISC-V instruction size.
package bp_fe_pc_next_pkg;

   localparam int eaddr_width_gp       = 32;
   localparam int bp_fe_instr_bytes_gp = 4;

   typedef logic [eaddr_width_gp-1:0] eaddr_t;

   typedef enum logic [1:0] {
      e_boot  = 2'd0,
      e_run   = 2'd1,
      e_flush = 2'd2
   } bp_fe_pc_state_e;

endpackage

// File: rtl/bp_fe_pc_next_if.sv
// Next-PC generator signal bundle: backend redirect, RAS prediction in,
// fetch PC handshake and status pulses out.
interface bp_fe_pc_next_if #(parameter int eaddr_width_p = 32);

   logic                     redirect_v_i;
   logic [eaddr_width_p-1:0] redirect_pc_i;
   logic [eaddr_width_p-1:0] ras_pc_i;
   logic                     ras_pc_v_i;
   logic                     fetch_ready_i;
   logic [eaddr_width_p-1:0] pc_o;
   logic                     pc_v_o;
   logic                     ras_taken_o;
   logic                     redirect_ack_o;

   modport slave (
      input  redirect_v_i, redirect_pc_i, ras_pc_i, ras_pc_v_i, fetch_ready_i,
      output pc_o, pc_v_o, ras_taken_o, redirect_ack_o
   );

   modport master (
      output redirect_v_i, redirect_pc_i, ras_pc_i, ras_pc_v_i, fetch_ready_i,
      input  pc_o, pc_v_o, ras_taken_o, redirect_ack_o
   );

endinterface

// File: rtl/bp_fe_pc_next_sel.sv
// Combinational next-state logic: priority select of redirect, RAS target and
// sequential PC, plus the enables for the one-cycle status pulses.
module bp_fe_pc_next_sel
   import bp_fe_pc_next_pkg::*;
#(
   parameter int eaddr_width_p = eaddr_width_gp,
   parameter int instr_bytes_p = bp_fe_instr_bytes_gp
)(
   input  bp_fe_pc_state_e          state_i,
   input  logic [eaddr_width_p-1:0] pc_i,
   input  logic                     redirect_v_i,
   input  logic [eaddr_width_p-1:0] redirect_pc_i,
   input  logic [eaddr_width_p-1:0] ras_pc_i,
   input  logic                     ras_pc_v_i,
   input  logic                     fetch_ready_i,
   output bp_fe_pc_state_e          state_o,
   output logic [eaddr_width_p-1:0] pc_o,
   output logic                     ras_taken_o,
   output logic                     redirect_ack_o
);

   logic fire;
   assign fire = (state_i == e_run) & fetch_ready_i;

   always_comb begin
      state_o        = state_i;
      pc_o           = pc_i;
      ras_taken_o    = 1'b0;
      redirect_ack_o = 1'b0;
      // Redirect wins in every state and squashes whatever PC is on offer.
      if (redirect_v_i) begin
         pc_o           = {redirect_pc_i[eaddr_width_p-1:2], 2'b00};
         state_o        = e_flush;
         redirect_ack_o = 1'b1;
      end else begin
         unique case (state_i)
            e_boot, e_flush: state_o = e_run;
            e_run: begin
               if (fire && ras_pc_v_i) begin
                  pc_o        = {ras_pc_i[eaddr_width_p-1:2], 2'b00};
                  ras_taken_o = 1'b1;
               end else if (fire) begin
                  pc_o = pc_i + eaddr_width_p'(instr_bytes_p);
               end
            end
            default: state_o = e_boot;
         endcase
      end
   end

endmodule

// File: rtl/bp_fe_pc_next.sv
// Front-end next-PC generator: owns the fetch PC register and the
// BOOT/RUN/FLUSH state that gates pc_v_o.
module bp_fe_pc_next
   import bp_fe_pc_next_pkg::*;
#(
   parameter int                     eaddr_width_p = eaddr_width_gp,
   parameter logic [eaddr_width_p-1:0] boot_pc_p   = 32'h8000_0000,
   parameter int                     instr_bytes_p = bp_fe_instr_bytes_gp
)(
   input  logic           clk_i,
   input  logic           reset_i,
   bp_fe_pc_next_if.slave io
);

   bp_fe_pc_state_e          state_q, state_d;
   logic [eaddr_width_p-1:0] pc_q, pc_d;
   logic                     ras_taken_q, ras_taken_d;
   logic                     redirect_ack_q, redirect_ack_d;

   bp_fe_pc_next_sel #(
      .eaddr_width_p (eaddr_width_p),
      .instr_bytes_p (instr_bytes_p)
   ) u_sel (
      .state_i        (state_q),
      .pc_i           (pc_q),
      .redirect_v_i   (io.redirect_v_i),
      .redirect_pc_i  (io.redirect_pc_i),
      .ras_pc_i       (io.ras_pc_i),
      .ras_pc_v_i     (io.ras_pc_v_i),
      .fetch_ready_i  (io.fetch_ready_i),
      .state_o        (state_d),
      .pc_o           (pc_d),
      .ras_taken_o    (ras_taken_d),
      .redirect_ack_o (redirect_ack_d)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= e_boot;
         pc_q           <= boot_pc_p;
         ras_taken_q    <= 1'b0;
         redirect_ack_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ras_taken_q    <= ras_taken_d;
         redirect_ack_q <= redirect_ack_d;
      end
   end

   assign io.pc_o           = pc_q;
   assign io.pc_v_o         = (state_q == e_run);
   assign io.ras_taken_o    = ras_taken_q;
   assign io.redirect_ack_o = redirect_ack_q;

endmodule
